// File: rtl/keypad_scanner.sv
// Keypad matrix scanner.
//
// Drives one active-low column at a time, samples the active-low rows after a settle time, and
// assembles a full-matrix frame. A frame must be seen unchanged for StableScans consecutive
// scans before it is published on keys_o.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous reset, active-low
//   row_i         raw row pads, active-low, asynchronous to clk_i
//   col_o         column drive, active-low (one bit low while scanning, all high otherwise)
//   keys_o        debounced key bitmap, 1 = pressed, bit index r*Cols + c
//   key_change_o  one-cycle pulse coincident with any keys_o update
//   scan_done_o   one-cycle pulse at the end of every full scan
module keypad_scanner #(
  parameter int unsigned Rows         = 4,
  parameter int unsigned Cols         = 4,
  parameter int unsigned SettleCycles = 100,
  parameter int unsigned StableScans  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [Rows-1:0]        row_i,
  output logic [Cols-1:0]        col_o,
  output logic [Rows*Cols-1:0]   keys_o,
  output logic                   key_change_o,
  output logic                   scan_done_o
);

  localparam int unsigned NumKeys = Rows * Cols;
  localparam int unsigned ColW    = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int unsigned SettleW = $clog2(SettleCycles);
  localparam int unsigned CntW    = $clog2(StableScans + 1);

  typedef enum logic [1:0] {
    StDrive,
    StSample,
    StEval
  } state_e;

  state_e               state_q, state_d;
  logic [Rows-1:0]      row_sync1_q, row_sync2_q;
  logic [Rows-1:0]      rows_act;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [ColW-1:0]      col_idx_q, col_idx_d;
  logic [Cols-1:0]      col_drv_q, col_drv_d;
  logic [NumKeys-1:0]   frame_q, frame_d;
  logic [NumKeys-1:0]   last_frame_q, last_frame_d;
  logic [NumKeys-1:0]   keys_q, keys_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_next;
  logic                 key_change_q, key_change_d;
  logic                 scan_done_q, scan_done_d;

  // Active-low one-hot column pattern for a column index.
  function automatic logic [Cols-1:0] col_drive(input logic [ColW-1:0] idx);
    logic [Cols-1:0] pat;
    pat = '1;
    for (int unsigned c = 0; c < Cols; c++) begin
      if (idx == ColW'(c)) pat[c] = 1'b0;
    end
    return pat;
  endfunction

  // Synchroniser resets to "no key pressed" (rows pulled high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_sync1_q <= '1;
      row_sync2_q <= '1;
    end else begin
      row_sync1_q <= row_i;
      row_sync2_q <= row_sync1_q;
    end
  end

  assign rows_act = ~row_sync2_q;

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    col_idx_d    = col_idx_q;
    col_drv_d    = col_drv_q;
    frame_d      = frame_q;
    last_frame_d = last_frame_q;
    keys_d       = keys_q;
    cnt_d        = cnt_q;
    cnt_next     = cnt_q;
    key_change_d = 1'b0;
    scan_done_d  = 1'b0;

    unique case (state_q)
      StDrive: begin
        // Also starts the column-0 drive on the first cycle after reset, since col_o resets
        // to all ones.
        col_drv_d = col_drive(col_idx_q);
        if (settle_q == SettleW'(SettleCycles - 1)) begin
          settle_d = '0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end

      StSample: begin
        for (int unsigned r = 0; r < Rows; r++) begin
          for (int unsigned c = 0; c < Cols; c++) begin
            if (col_idx_q == ColW'(c)) frame_d[r*Cols + c] = rows_act[r];
          end
        end
        if (col_idx_q == ColW'(Cols - 1)) begin
          col_drv_d = '1;
          state_d   = StEval;
        end else begin
          col_idx_d = col_idx_q + ColW'(1);
          col_drv_d = col_drive(col_idx_d);
          settle_d  = '0;
          state_d   = StDrive;
        end
      end

      StEval: begin
        if (frame_q == last_frame_q) begin
          cnt_next = (cnt_q == CntW'(StableScans)) ? cnt_q : cnt_q + CntW'(1);
        end else begin
          cnt_next     = CntW'(1);
          last_frame_d = frame_q;
        end
        cnt_d = cnt_next;
        if ((cnt_next == CntW'(StableScans)) && (frame_q != keys_q)) begin
          keys_d       = frame_q;
          key_change_d = 1'b1;
        end
        scan_done_d = 1'b1;
        col_idx_d   = '0;
        col_drv_d   = col_drive('0);
        settle_d    = '0;
        state_d     = StDrive;
      end

      default: begin
        col_idx_d = '0;
        col_drv_d = '1;
        settle_d  = '0;
        state_d   = StDrive;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StDrive;
      settle_q     <= '0;
      col_idx_q    <= '0;
      col_drv_q    <= '1;
      frame_q      <= '0;
      last_frame_q <= '0;
      keys_q       <= '0;
      cnt_q        <= '0;
      key_change_q <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      col_idx_q    <= col_idx_d;
      col_drv_q    <= col_drv_d;
      frame_q      <= frame_d;
      last_frame_q <= last_frame_d;
      keys_q       <= keys_d;
      cnt_q        <= cnt_d;
      key_change_q <= key_change_d;
      scan_done_q  <= scan_done_d;
    end
  end

  assign col_o        = col_drv_q;
  assign keys_o       = keys_q;
  assign key_change_o = key_change_q;
  assign scan_done_o  = scan_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with default parameters.
// A behavioural keypad model pulls row r low while key (r,c) is pressed and column c is driven.
module tb_keypad_scanner;

  localparam int unsigned Rows    = 4;
  localparam int unsigned Cols    = 4;
  localparam int unsigned NumKeys = Rows * Cols;

  logic               clk_i  = 1'b0;
  logic               rst_ni = 1'b0;
  logic [Rows-1:0]    row_i;
  logic [Cols-1:0]    col_o;
  logic [NumKeys-1:0] keys_o;
  logic               key_change_o;
  logic               scan_done_o;
  logic [NumKeys-1:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  keypad_scanner #(
    .Rows        (Rows),
    .Cols        (Cols),
    .SettleCycles(100),
    .StableScans (4)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .row_i       (row_i),
    .col_o       (col_o),
    .keys_o      (keys_o),
    .key_change_o(key_change_o),
    .scan_done_o (scan_done_o)
  );

  always_comb begin
    row_i = '1;
    for (int r = 0; r < Rows; r++) begin
      for (int c = 0; c < Cols; c++) begin
        if (pressed[r*Cols + c] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for n scan_done pulses (sampled on negedge), counting key_change pulses on the way.
  task automatic wait_scans(input int n, output int chg, output logic chg_at_done);
    int cyc;
    chg         = 0;
    chg_at_done = 1'b0;
    for (int s = 0; s < n; s++) begin
      cyc = 0;
      do begin
        @(negedge clk_i);
        cyc++;
        if (key_change_o) begin
          chg++;
          chg_at_done = scan_done_o;
        end
      end while (!scan_done_o && cyc < 1000);
      if (!scan_done_o) begin
        check("scan_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  initial begin
    int          chg;
    logic        at_done;
    int          col_errs;
    int          early_done;
    int          idle_chg;
    logic [15:0] idle_keys;
    logic [3:0]  one;
    logic [3:0]  exp_col;
    int          cyc;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_col", col_o, 32'hF);
    check("rst_keys", keys_o, 32'h0);
    check("rst_chg", key_change_o, 32'h0);
    check("rst_done", scan_done_o, 32'h0);

    rst_ni = 1'b1;
    @(negedge clk_i);
    check("start_col0", col_o, 32'hE);
    wait_scans(1, chg, at_done);
    check("idle_keys_first", keys_o, 32'h0);
    check("idle_chg_first", chg, 32'd0);

    // One full period of column sequence, starting on the scan_done cycle
    col_errs   = 0;
    early_done = 0;
    idle_chg   = 0;
    idle_keys  = '0;
    one        = 4'b0001;
    for (int i = 0; i < 405; i++) begin
      if (i > 0) @(negedge clk_i);
      exp_col = (i < 404) ? ~(one << (i / 101)) : 4'hF;
      if (col_o !== exp_col) col_errs++;
      if (i > 0 && scan_done_o) early_done++;
      if (key_change_o) idle_chg++;
      idle_keys |= keys_o;
    end
    check("col_seq_errs", col_errs, 32'd0);
    check("scan_done_early", early_done, 32'd0);
    @(negedge clk_i);
    check("scan_done_period", scan_done_o, 32'd1);
    check("idle_keys", idle_keys, 32'h0);
    check("idle_chg", idle_chg, 32'd0);

    // Press (1,2) and hold
    pressed = 16'h0040;
    wait_scans(3, chg, at_done);
    check("press_keys_3", keys_o, 32'h0);
    check("press_chg_3", chg, 32'd0);
    wait_scans(1, chg, at_done);
    check("press_keys_4", keys_o, 32'h0040);
    check("press_chg_4", chg, 32'd1);
    check("press_chg_at_done", at_done, 32'd1);
    wait_scans(2, chg, at_done);
    check("hold_keys", keys_o, 32'h0040);
    check("hold_chg", chg, 32'd0);

    // Release
    pressed = '0;
    wait_scans(3, chg, at_done);
    check("rel_keys_3", keys_o, 32'h0040);
    check("rel_chg_3", chg, 32'd0);
    wait_scans(1, chg, at_done);
    check("rel_keys_4", keys_o, 32'h0);
    check("rel_chg_4", chg, 32'd1);

    // Bounce on (0,0) for 6 scans, then hold
    idle_chg  = 0;
    idle_keys = '0;
    for (int s = 0; s < 6; s++) begin
      pressed[0] = (s % 2 == 0);
      wait_scans(1, chg, at_done);
      idle_chg += chg;
      idle_keys |= keys_o;
    end
    check("bounce_keys", idle_keys, 32'h0);
    check("bounce_chg", idle_chg, 32'd0);
    pressed[0] = 1'b1;
    wait_scans(3, chg, at_done);
    check("bounce_hold_keys_3", keys_o, 32'h0);
    check("bounce_hold_chg_3", chg, 32'd0);
    wait_scans(1, chg, at_done);
    check("bounce_hold_keys_4", keys_o, 32'h0001);
    check("bounce_hold_chg_4", chg, 32'd1);

    // Two keys together: (3,3) and (2,0)
    pressed = 16'h8100;
    wait_scans(3, chg, at_done);
    check("multi_keys_3", keys_o, 32'h0001);
    check("multi_chg_3", chg, 32'd0);
    wait_scans(1, chg, at_done);
    check("multi_keys_4", keys_o, 32'h8100);
    check("multi_chg_4", chg, 32'd1);

    // Asynchronous reset while column 2 is driven
    cyc = 0;
    while (col_o !== 4'b1011 && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
    end
    check("find_col2", col_o, 32'hB);
    repeat (20) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_col", col_o, 32'hF);
    check("midrst_keys", keys_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("restart_col0", col_o, 32'hE);
    wait_scans(3, chg, at_done);
    check("restart_keys_3", keys_o, 32'h0);
    check("restart_chg_3", chg, 32'd0);
    wait_scans(1, chg, at_done);
    check("restart_keys_4", keys_o, 32'h8100);
    check("restart_chg_4", chg, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
